// File: rtl/nw_credit_pkg.sv
// nw_credit_pkg: constants shared by the output credit gate and its per-VC counters.
//   cnt_width()      - width of a credit counter holding 0..depth inclusive
//   ERR_*            - bit positions inside err_flags
//   err_flags_t      - packed type of the sticky error vector
package nw_credit_pkg;

    localparam int unsigned ERR_W           = 3;
    localparam int unsigned ERR_UNDERFLOW   = 0;
    localparam int unsigned ERR_OVERFLOW    = 1;
    localparam int unsigned ERR_MULTI_GRANT = 2;

    typedef logic [ERR_W-1:0] err_flags_t;

    // Counter must represent the full depth value, not just depth-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nw_credit_counter.sv
// nw_credit_counter: credit count for one downstream virtual channel.
// Resets to CREDIT_DEPTH (downstream buffer empty). Simultaneous inc and dec cancel.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   inc         - credit returned for this VC
//   dec         - committed send on this VC
//   cnt         - current credit count (registered)
//   underflow   - dec at count 0 this cycle (count held at 0)
//   overflow    - inc at full count this cycle (count saturated)
module nw_credit_counter
    import nw_credit_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = 4,
    localparam int unsigned CNT_W = cnt_width(CREDIT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        overflow  = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == FULL) overflow = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q == '0) underflow = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= FULL;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nw_output_credit_gate.sv
// nw_output_credit_gate: qualifies per-VC send requests with downstream credit,
// consumes a credit on each committed grant, and issues a registered send command.
// Optional build macro: NW_CREDIT_BYPASS_EN - a credit returned in the same cycle
// to an empty VC qualifies that VC's request immediately.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   vc_request       - raw per-VC requests
//   arb_request      - credit-qualified requests to the switch arbiter (combinational)
//   grant, success   - arbiter grant vector and commit strobe
//   credit_in_valid  - credit return strobe, credit_in_vc selects the VC
//   send_valid/vc    - registered send command, one cycle after a commit
//   vc_has_credit    - per-VC non-zero credit count
//   err_flags        - sticky [0] underflow, [1] overflow, [2] multi-grant
module nw_output_credit_gate
    import nw_credit_pkg::*;
#(
    parameter int unsigned NUM_VCS      = 4,
    parameter int unsigned CREDIT_DEPTH = 4,
    localparam int unsigned VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int unsigned CNT_W = cnt_width(CREDIT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_VCS-1:0] vc_request,
    output logic [NUM_VCS-1:0] arb_request,
    input  logic [NUM_VCS-1:0] grant,
    input  logic               success,
    input  logic               credit_in_valid,
    input  logic [VC_W-1:0]    credit_in_vc,
    output logic               send_valid,
    output logic [VC_W-1:0]    send_vc,
    output logic [NUM_VCS-1:0] vc_has_credit,
    output logic [ERR_W-1:0]   err_flags
);

    logic [CNT_W-1:0]   cnt [NUM_VCS];
    logic [NUM_VCS-1:0] inc, dec, underflow, overflow;
    logic               commit, multi_grant, credit_ok;
    logic [VC_W-1:0]    grant_idx;
    err_flags_t         err_now;

    logic               send_valid_q;
    logic [VC_W-1:0]    send_vc_q;
    err_flags_t         err_q;

    // Only a one-hot grant under success is a real send; zero grant is a no-op.
    assign commit      = success && $onehot(grant);
    assign multi_grant = success && !$onehot0(grant);
    // Out-of-range VC indices are dropped.
    assign credit_ok   = credit_in_valid && (32'(credit_in_vc) < NUM_VCS);

    always_comb begin
        grant_idx = '0;
        for (int v = 0; v < int'(NUM_VCS); v++) begin
            if (grant[v]) grant_idx = VC_W'(v);
        end
    end

    for (genvar v = 0; v < int'(NUM_VCS); v++) begin : g_vc
        assign inc[v] = credit_ok && (credit_in_vc == VC_W'(v));
        assign dec[v] = commit && grant[v];

        nw_credit_counter #(
            .CREDIT_DEPTH (CREDIT_DEPTH)
        ) u_counter (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc[v]),
            .dec       (dec[v]),
            .cnt       (cnt[v]),
            .underflow (underflow[v]),
            .overflow  (overflow[v])
        );

        assign vc_has_credit[v] = (cnt[v] != '0);
`ifdef NW_CREDIT_BYPASS_EN
        assign arb_request[v] = vc_request[v] & (vc_has_credit[v] | inc[v]);
`else
        assign arb_request[v] = vc_request[v] & vc_has_credit[v];
`endif
    end

    always_comb begin
        err_now                  = '0;
        err_now[ERR_UNDERFLOW]   = |underflow;
        err_now[ERR_OVERFLOW]    = |overflow;
        err_now[ERR_MULTI_GRANT] = multi_grant;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            send_valid_q <= 1'b0;
            send_vc_q    <= '0;
            err_q        <= '0;
        end else begin
            send_valid_q <= commit;
            if (commit) send_vc_q <= grant_idx;
            err_q <= err_q | err_now;
        end
    end

    assign send_valid = send_valid_q;
    assign send_vc    = send_vc_q;
    assign err_flags  = err_q;

endmodule

// File: tb/tb_nw_output_credit_gate.sv
module tb_nw_output_credit_gate;

    localparam int unsigned NUM_VCS = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_VCS-1:0] vc_request;
    logic [NUM_VCS-1:0] arb_request;
    logic [NUM_VCS-1:0] grant;
    logic               success;
    logic               credit_in_valid;
    logic [1:0]         credit_in_vc;
    logic               send_valid;
    logic [1:0]         send_vc;
    logic [NUM_VCS-1:0] vc_has_credit;
    logic [2:0]         err_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    nw_output_credit_gate #(
        .NUM_VCS      (NUM_VCS),
        .CREDIT_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vc_request      (vc_request),
        .arb_request     (arb_request),
        .grant           (grant),
        .success         (success),
        .credit_in_valid (credit_in_valid),
        .credit_in_vc    (credit_in_vc),
        .send_valid      (send_valid),
        .send_vc         (send_vc),
        .vc_has_credit   (vc_has_credit),
        .err_flags       (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented send must match the oldest expected commit.
    always @(negedge clk) begin
        int e;
        if (send_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_send: got send_vc=%0d expected no send", send_vc);
            end else begin
                e = exp_q.pop_front();
                chk("send_vc", 32'(send_vc), 32'(e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        grant           = '0;
        success         = 1'b0;
        credit_in_valid = 1'b0;
        credit_in_vc    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vc_request = '0;
        rst_n      = 1'b0;
        idle();
        cyc();
        cyc();
        #1;
        chk("rst_send_valid", 32'(send_valid), 0);
        chk("rst_send_vc", 32'(send_vc), 0);
        chk("rst_err", 32'(err_flags), 0);
        chk("rst_has_credit", 32'(vc_has_credit), 32'hf);
        for (int v = 0; v < 4; v++) chk("rst_cnt", 32'(dut.cnt[v]), 4);
        vc_request = 4'b1111;
        #1 chk("rst_arb", 32'(arb_request), 32'hf);

        // All credits available after reset
        rst_n = 1'b1;
        cyc();
        #1;
        chk("arb_after_reset", 32'(arb_request), 32'hf);
        chk("has_after_reset", 32'(vc_has_credit), 32'hf);

        // Drain VC2 with four commits
        grant   = 4'b0100;
        success = 1'b1;
        repeat (4) begin
            exp_q.push_back(2);
            cyc();
        end
        idle();
        #1;
        chk("vc2_drained_arb", 32'(arb_request), 32'hb);
        chk("vc2_drained_has", 32'(vc_has_credit), 32'hb);
        chk("vc2_drained_cnt", 32'(dut.cnt[2]), 0);
        credit_in_valid = 1'b1;
        credit_in_vc    = 2'd2;
        #1;
`ifdef NW_CREDIT_BYPASS_EN
        chk("vc2_credit_same_cycle_arb", 32'(arb_request), 32'hf);
`else
        chk("vc2_credit_same_cycle_arb", 32'(arb_request), 32'hb);
`endif
        cyc();
        idle();
        #1;
        chk("vc2_credit_next_arb", 32'(arb_request), 32'hf);
        chk("vc2_credit_cnt", 32'(dut.cnt[2]), 1);

        // Commit and credit on VC1 together: count unchanged, no overflow
        grant           = 4'b0010;
        success         = 1'b1;
        credit_in_valid = 1'b1;
        credit_in_vc    = 2'd1;
        exp_q.push_back(1);
        cyc();
        idle();
        #1;
        chk("vc1_cancel_cnt", 32'(dut.cnt[1]), 4);
        chk("vc1_cancel_err", 32'(err_flags), 0);
        cyc();
        #1;
        chk("idle_send_valid", 32'(send_valid), 0);
        chk("idle_send_vc_hold", 32'(send_vc), 1);

        // Multi-bit grant under success
        grant   = 4'b0110;
        success = 1'b1;
        cyc();
        idle();
        #1;
        chk("multi_send_valid", 32'(send_valid), 0);
        chk("multi_err", 32'(err_flags), 32'h4);
        chk("multi_cnt1", 32'(dut.cnt[1]), 4);
        chk("multi_cnt2", 32'(dut.cnt[2]), 1);

        // Grant without success is ignored
        grant = 4'b0001;
        cyc();
        idle();
        #1;
        chk("nosuccess_send_valid", 32'(send_valid), 0);
        chk("nosuccess_err", 32'(err_flags), 32'h4);
        chk("nosuccess_cnt0", 32'(dut.cnt[0]), 4);

        // Overflow on VC0 at full count
        credit_in_valid = 1'b1;
        credit_in_vc    = 2'd0;
        cyc();
        idle();
        #1;
        chk("overflow_err", 32'(err_flags), 32'h6);
        chk("overflow_cnt0", 32'(dut.cnt[0]), 4);

        // Underflow: VC2 has one credit, commit twice
        grant   = 4'b0100;
        success = 1'b1;
        exp_q.push_back(2);
        cyc();
        exp_q.push_back(2);
        cyc();
        idle();
        #1;
        chk("underflow_cnt2", 32'(dut.cnt[2]), 0);
        chk("underflow_err", 32'(err_flags), 32'h7);

        // Drain VC3, then return a credit and watch same-cycle arb_request
        grant   = 4'b1000;
        success = 1'b1;
        repeat (4) begin
            exp_q.push_back(3);
            cyc();
        end
        idle();
        vc_request = 4'b1000;
        #1;
        chk("vc3_drained_cnt", 32'(dut.cnt[3]), 0);
        chk("vc3_drained_arb", 32'(arb_request), 0);
        credit_in_valid = 1'b1;
        credit_in_vc    = 2'd3;
        #1;
`ifdef NW_CREDIT_BYPASS_EN
        chk("vc3_bypass_arb", 32'(arb_request), 32'h8);
`else
        chk("vc3_bypass_arb", 32'(arb_request), 0);
`endif
        cyc();
        idle();
        #1;
        chk("vc3_credit_next_arb", 32'(arb_request), 32'h8);
        chk("vc3_credit_cnt", 32'(dut.cnt[3]), 1);

        // Commit and credit coincident with reset are discarded
        vc_request      = 4'b1111;
        grant           = 4'b0001;
        success         = 1'b1;
        credit_in_valid = 1'b1;
        credit_in_vc    = 2'd3;
        rst_n           = 1'b0;
        cyc();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rst2_send_valid", 32'(send_valid), 0);
        chk("rst2_err", 32'(err_flags), 0);
        chk("rst2_cnt0", 32'(dut.cnt[0]), 4);
        chk("rst2_cnt2", 32'(dut.cnt[2]), 4);
        chk("rst2_cnt3", 32'(dut.cnt[3]), 4);
        chk("rst2_has", 32'(vc_has_credit), 32'hf);
        chk("rst2_arb", 32'(arb_request), 32'hf);

        cyc();
        cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nw_output_credit_gate.md
NW_OUTPUT_CREDIT_GATE -- requirements
Module: nw_output_credit_gate

Interface
REQ-001 SHALL have parameter NUM_VCS, default 4: number of downstream virtual channels, one arbiter request bit per VC.
REQ-002 SHALL have parameter CREDIT_DEPTH, default 4: downstream buffer depth per VC, in flits.
REQ-003 SHALL have port clk  input  1  clock; reset rst_n, synchronous, active-low; clock clk.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port vc_request  input  NUM_VCS  raw per-VC send requests from the input stage.
REQ-006 SHALL have port arb_request  output  NUM_VCS  credit-qualified requests driven to the switch arbiter.
REQ-007 SHALL have port grant  input  NUM_VCS  arbiter grant vector, one-hot or zero.
REQ-008 SHALL have port success  input  1  grant is committed this cycle; the same signal drives the arbiter's success input.
REQ-009 SHALL have port credit_in_valid  input  1  downstream credit return strobe.
REQ-010 SHALL have port credit_in_vc  input  $clog2(NUM_VCS)  VC index of the returned credit.
REQ-011 SHALL have port send_valid  output  1  registered flit-send command.
REQ-012 SHALL have port send_vc  output  $clog2(NUM_VCS)  registered VC index of the send command.
REQ-013 SHALL have port vc_has_credit  output  NUM_VCS  per-VC credit count non-zero (registered state).
REQ-014 SHALL have port err_flags  output  3  sticky errors: [0] underflow, [1] overflow, [2] multi-grant.

Function
REQ-015 SHALL keep one counter cnt[v] per VC, width $clog2(CREDIT_DEPTH+1), with range 0..CREDIT_DEPTH.
REQ-016 SHALL drive arb_request[v] combinationally as vc_request[v] & (cnt[v]!=0).
REQ-017 SHALL define a commit as success=1 and grant exactly one-hot; on a commit to VC v, cnt[v] decrements at the next edge.
REQ-018 SHALL, when credit_in_valid=1, increment cnt[credit_in_vc] at the next edge.
REQ-019 SHALL leave the count unchanged when a commit and a credit return hit the same VC in the same cycle.
REQ-020 SHALL, on a commit to a VC with cnt=0, leave cnt at 0 and set err_flags[0].
REQ-021 SHALL, on a credit return to a VC with cnt=CREDIT_DEPTH and no same-cycle commit to it, saturate cnt and set err_flags[1].
REQ-022 SHALL, when success=1 and grant has more than one bit set, decrement no counter, assert no send, and set err_flags[2].
REQ-023 SHALL ignore grant while success=0: no decrement, no send, no error.
REQ-024 SHALL register send_valid/send_vc one cycle after a commit; send_valid=0 in cycles after a non-commit, with send_vc holding its last value.
REQ-025 SHALL treat credit_in_vc >= NUM_VCS as a no-op.
REQ-026 SHALL hold err_flags bits sticky until reset.

Reset
REQ-027 SHALL, with rst_n=0 at a clk edge, set every cnt to CREDIT_DEPTH, vc_has_credit to all-ones, send_valid to 0, send_vc to 0, and err_flags to 0.
REQ-028 SHALL discard a commit or credit return coincident with reset; arb_request still follows REQ-016 using the reset counts.

Configuration
REQ-029 SHALL support macro NW_CREDIT_BYPASS_EN; when defined, arb_request[v] is also asserted when cnt[v]=0, vc_request[v]=1, and credit_in_valid=1 with credit_in_vc=v in the same cycle.
REQ-030 SHALL, with NW_CREDIT_BYPASS_EN undefined, implement exactly REQ-016 (returned credit is usable from the next cycle).

Structure
REQ-031 SHALL place the counter-width constant/typedef and the err_flags bit-index constants in shared package nw_credit_pkg.
REQ-032 SHALL instantiate one sub-module nw_credit_counter per VC, handling increment, decrement, saturation, and per-VC error detection.

Verification
REQ-033 SHALL cover: after reset, vc_request=4'b1111 -> arb_request=4'b1111 and vc_has_credit=4'b1111.
REQ-034 SHALL cover: 4 commits to VC2, then vc_request[2]=1 -> arb_request[2]=0 and vc_has_credit[2]=0; one credit to VC2 -> arb_request[2]=1 the next cycle.
REQ-035 SHALL cover: commit to VC1 and credit to VC1 in the same cycle -> cnt[1] unchanged, send_valid=1 and send_vc=1 next cycle.
REQ-036 SHALL cover: grant=4'b0110 with success=1 -> no send, no count change, err_flags=3'b100.
REQ-037 SHALL cover: credit to VC0 at full count -> err_flags[1]=1 and cnt[0]=4; a commit at cnt=0 -> err_flags[0]=1 and cnt stays 0.
REQ-038 SHALL cover: with NW_CREDIT_BYPASS_EN, VC3 at cnt=0 plus a same-cycle credit to VC3 -> arb_request[3]=1 that cycle; without the macro -> arb_request[3]=0 that cycle.
